period_meter: RTL

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 107 ++++++++++
 1 files changed

// File: rtl/period_meter.sv
// period_meter: measures the period and high time of a slow, asynchronous
// square wave in clk cycles. Measurements start after two rising edges and
// stop (with a lost flag) when no edge arrives before the counter saturates.
module period_meter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             locked,
   output logic             lost
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   state_t           state;
   logic             s1;
   logic             s2;
   logic             s3;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] hcnt;
   logic             rise;
   logic             cnt_sat;

   assign rise    = s2 & ~s3;
   assign cnt_sat = (cnt == CNT_MAX);

   // Two-flop synchronizer for sig_in plus one history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Period and high-time counters: restart at 1 on a rise, otherwise count
   // up and saturate at all-ones so they can never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         hcnt <= '0;
      end else if (rise) begin
         cnt  <= CNT_ONE;
         hcnt <= CNT_ONE;
      end else if (!cnt_sat) begin
         cnt <= cnt + CNT_ONE;
         if (s2) begin
            hcnt <= hcnt + CNT_ONE;
         end
      end
   end

   // Control FSM with registered outputs; a rise always wins over a timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         lost      <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= ARMED;
               end
            end
            ARMED, LOCKED: begin
               if (rise) begin
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  period    <= cnt;
                  high_time <= hcnt;
                  valid     <= 1'b1;
                  lost      <= 1'b0;
               end else if (cnt_sat) begin
                  state  <= IDLE;
                  locked <= 1'b0;
                  lost   <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule
